// File: rtl/filter_pkg.sv
// Shared parameters and FSM encoding for the packet filter IP.
package filter_pkg;
  localparam int TAG_WIDTH            = 6;
  localparam int CIRCULAR_BUFFER_SIZE = 50;
  localparam int DATA_WIDTH           = 64;
  localparam int N_CORES              = 4;
  localparam int MAX_TDATA_PER_PACKET = 375;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } fwd_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // i_ptr is always < N, so ptr+i never exceeds 2N-2 and one subtraction wraps it.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_sum         = '0;
    w_cand        = '0;
    for (int i = 0; i < N; i++) begin
      w_sum  = {1'b0, i_ptr} + (IW+1)'(i);
      w_cand = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant_valid   = 1'b1;
        o_grant_idx     = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/packet_forwarder.sv
// Ingress stage: tags each packet, fans beats out to the circular buffer and one
// round-robin selected core, and throttles when every buffer slot is in flight.
//
// Handshake: a beat moves on a sink only when that sink's VALID and READY are both
// high at the rising edge; VALID never depends on the same sink's READY, and both
// sinks take a beat in exactly the same cycle.
module packet_forwarder
  import filter_pkg::*;
#(
  parameter int TAG_WIDTH_P            = TAG_WIDTH,
  parameter int CIRCULAR_BUFFER_SIZE_P = CIRCULAR_BUFFER_SIZE,
  parameter int DATA_WIDTH_P           = DATA_WIDTH,
  parameter int N_CORES_P              = N_CORES,
  parameter int MAX_TDATA_PER_PACKET_P = MAX_TDATA_PER_PACKET
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH_P-1:0]      in_TDATA,
  input  logic                         in_TLAST,
  input  logic                         in_TVALID,
  output logic                         in_TREADY,
  output logic [DATA_WIDTH_P-1:0]      buffer_TDATA,
  output logic                         buffer_TLAST,
  output logic                         buffer_TVALID,
  input  logic                         buffer_TREADY,
  output logic [TAG_WIDTH_P-1:0]       reorder_tag_in,
  output logic [DATA_WIDTH_P-1:0]      core_TDATA,
  output logic                         core_TLAST,
  output logic [N_CORES_P-1:0]         core_TVALID,
  input  logic [N_CORES_P-1:0]         core_TREADY,
  input  logic [N_CORES_P-1:0]         core_idle,
  output logic [TAG_WIDTH_P-1:0]       core_tag,
  output logic                         tag_alloc_valid,
  output logic [TAG_WIDTH_P-1:0]       tag_alloc,
  output logic [$clog2(N_CORES_P)-1:0] tag_alloc_core,
  input  logic                         tag_release,
  output logic [1:0]                   o_dbg_state
);
  localparam int CW = $clog2(N_CORES_P);
  localparam int OW = $clog2(CIRCULAR_BUFFER_SIZE_P + 1);
  localparam int BW = $clog2(MAX_TDATA_PER_PACKET_P + 1);
  localparam logic [TAG_WIDTH_P-1:0] TAG_LAST  = TAG_WIDTH_P'(CIRCULAR_BUFFER_SIZE_P - 1);
  localparam logic [OW-1:0]          OUT_FULL  = OW'(CIRCULAR_BUFFER_SIZE_P);
  localparam logic [BW-1:0]          BEAT_LAST = BW'(MAX_TDATA_PER_PACKET_P - 1);
  localparam logic [CW-1:0]          CORE_LAST = CW'(N_CORES_P - 1);

  fwd_state_t             r_state;
  logic [TAG_WIDTH_P-1:0] r_tag_ptr;
  logic [TAG_WIDTH_P-1:0] r_tag;
  logic [OW-1:0]          r_outstanding;
  logic [CW-1:0]          r_rr_ptr;
  logic [BW-1:0]          r_beat_cnt;
  logic [CW-1:0]          r_sel;
  logic                   r_alloc_valid;
  logic [TAG_WIDTH_P-1:0] r_alloc_tag;
  logic [CW-1:0]          r_alloc_core;

  logic [N_CORES_P-1:0] w_grant;
  logic [CW-1:0]        w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_start;
  logic                 w_accept;
  logic                 w_last_out;
  logic                 w_sel_ready;

  rr_arbiter #(.N(N_CORES_P), .IW(CW)) u_rr_arbiter (
    .i_req         (core_idle),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_sel_ready = core_TREADY[r_sel];
  assign w_start     = (r_state == ST_IDLE) && in_TVALID &&
                       (r_outstanding < OUT_FULL) && w_grant_valid;
  assign w_accept    = (r_state == ST_STREAM) && in_TVALID && in_TREADY;
  assign w_last_out  = in_TLAST || (r_beat_cnt == BEAT_LAST);

  // Data and TLAST are gated outside STREAM so idle/reset outputs read as zero.
  always_comb begin
    in_TREADY     = 1'b0;
    buffer_TVALID = 1'b0;
    buffer_TDATA  = '0;
    buffer_TLAST  = 1'b0;
    core_TVALID   = '0;
    core_TDATA    = '0;
    core_TLAST    = 1'b0;
    if (r_state == ST_STREAM) begin
      in_TREADY          = buffer_TREADY && w_sel_ready;
      buffer_TVALID      = in_TVALID && w_sel_ready;
      core_TVALID[r_sel] = in_TVALID && buffer_TREADY;
      buffer_TDATA       = in_TDATA;
      core_TDATA         = in_TDATA;
      buffer_TLAST       = w_last_out;
      core_TLAST         = w_last_out;
    end else if (r_state == ST_DRAIN) begin
      in_TREADY = 1'b1;
    end
  end

  assign reorder_tag_in  = r_tag;
  assign core_tag        = r_tag;
  assign tag_alloc_valid = r_alloc_valid;
  assign tag_alloc       = r_alloc_tag;
  assign tag_alloc_core  = r_alloc_core;
  assign o_dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tag_ptr     <= '0;
      r_tag         <= '0;
      r_outstanding <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_sel         <= '0;
      r_alloc_valid <= 1'b0;
      r_alloc_tag   <= '0;
      r_alloc_core  <= '0;
    end else begin
      r_alloc_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sel         <= w_grant_idx;
            r_tag         <= r_tag_ptr;
            r_alloc_valid <= 1'b1;
            r_alloc_tag   <= r_tag_ptr;
            r_alloc_core  <= w_grant_idx;
            r_state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            if (w_last_out) begin
              r_tag_ptr  <= (r_tag_ptr == TAG_LAST) ? '0 : r_tag_ptr + 1'b1;
              r_rr_ptr   <= (r_sel == CORE_LAST) ? '0 : r_sel + 1'b1;
              r_beat_cnt <= '0;
              r_state    <= in_TLAST ? ST_IDLE : ST_DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (in_TVALID && in_TLAST) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A slot is held from allocation until the buffer side retires it.
      if (w_start && !tag_release) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_start && tag_release && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_packet_forwarder.sv
// Self-checking bench for packet_forwarder: packet-level model plus scoreboard queues.
module tb_packet_forwarder;
  import filter_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] in_TDATA;
  logic                  in_TLAST;
  logic                  in_TVALID;
  logic                  in_TREADY;
  logic [DATA_WIDTH-1:0] buffer_TDATA;
  logic                  buffer_TLAST;
  logic                  buffer_TVALID;
  logic                  buffer_TREADY;
  logic [TAG_WIDTH-1:0]  reorder_tag_in;
  logic [DATA_WIDTH-1:0] core_TDATA;
  logic                  core_TLAST;
  logic [N_CORES-1:0]    core_TVALID;
  logic [N_CORES-1:0]    core_TREADY;
  logic [N_CORES-1:0]    core_idle;
  logic [TAG_WIDTH-1:0]  core_tag;
  logic                  tag_alloc_valid;
  logic [TAG_WIDTH-1:0]  tag_alloc;
  logic [1:0]            tag_alloc_core;
  logic                  tag_release;
  logic [1:0]            o_dbg_state;

  packet_forwarder dut (
    .clk(clk), .rst_n(rst_n),
    .in_TDATA(in_TDATA), .in_TLAST(in_TLAST), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
    .buffer_TDATA(buffer_TDATA), .buffer_TLAST(buffer_TLAST),
    .buffer_TVALID(buffer_TVALID), .buffer_TREADY(buffer_TREADY),
    .reorder_tag_in(reorder_tag_in),
    .core_TDATA(core_TDATA), .core_TLAST(core_TLAST),
    .core_TVALID(core_TVALID), .core_TREADY(core_TREADY), .core_idle(core_idle),
    .core_tag(core_tag),
    .tag_alloc_valid(tag_alloc_valid), .tag_alloc(tag_alloc), .tag_alloc_core(tag_alloc_core),
    .tag_release(tag_release), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [70:0] exp_buf_q[$];    // {tag, last, data}
  logic [72:0] exp_core_q[$];   // {core, tag, last, data}
  logic [7:0]  exp_alloc_q[$];  // {core, tag}
  int obs_tag[$];
  int obs_core[$];
  int n_buf_beats = 0;
  int n_buf_lasts = 0;
  int drain_stalls = 0;

  // packet-level model state
  int m_tag = 0;
  int m_rr  = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic int pick_core(input logic [N_CORES-1:0] idle, input int rr);
    for (int i = 0; i < N_CORES; i++) begin
      if (idle[(rr + i) % N_CORES]) return (rr + i) % N_CORES;
    end
    return -1;
  endfunction

  // ---------------- compare process ----------------
  logic        b_hs, c_hs;
  int          c_idx;
  logic [70:0] eb;
  logic [72:0] ec;
  logic [7:0]  ea;

  always begin
    @(negedge clk);
    #4;
    b_hs  = buffer_TVALID & buffer_TREADY;
    c_hs  = |(core_TVALID & core_TREADY);
    c_idx = 0;
    for (int k = 0; k < N_CORES; k++) if (core_TVALID[k] & core_TREADY[k]) c_idx = k;
    if (core_TVALID != '0) check("core_valid_onehot", 80'($countones(core_TVALID)), 80'd1);
    if (b_hs || c_hs) check("sink_lockstep", 80'(c_hs), 80'(b_hs));
    if (b_hs) begin
      n_buf_beats++;
      if (buffer_TLAST) n_buf_lasts++;
      if (exp_buf_q.size() == 0) check("buf_extra_beat", 80'd1, 80'd0);
      else begin
        eb = exp_buf_q.pop_front();
        check("buf_beat", 80'({reorder_tag_in, buffer_TLAST, buffer_TDATA}), 80'(eb));
      end
    end
    if (c_hs) begin
      if (exp_core_q.size() == 0) check("core_extra_beat", 80'd1, 80'd0);
      else begin
        ec = exp_core_q.pop_front();
        check("core_beat", 80'({2'(c_idx), core_tag, core_TLAST, core_TDATA}), 80'(ec));
      end
    end
    if (tag_alloc_valid) begin
      obs_tag.push_back(int'(tag_alloc));
      obs_core.push_back(int'(tag_alloc_core));
      if (exp_alloc_q.size() == 0) check("alloc_extra", 80'd1, 80'd0);
      else begin
        ea = exp_alloc_q.pop_front();
        check("alloc", 80'({tag_alloc_core, tag_alloc}), 80'(ea));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [63:0] d, input logic l, input int idx);
    bit acc;
    int cyc;
    acc = 0;
    cyc = 0;
    @(negedge clk);
    in_TVALID = 1'b1;
    in_TDATA  = d;
    in_TLAST  = l;
    while (!acc) begin
      #4;
      acc = in_TREADY;
      if (!acc && idx > MAX_TDATA_PER_PACKET) drain_stalls++;
      @(posedge clk);
      if (!acc) begin
        cyc++;
        if (cyc > 200) begin
          check("beat_accept_timeout", 80'd0, 80'd1);
          finish_run();
        end
        @(negedge clk);
      end
    end
  endtask

  // Predicts allocation, tag and (possibly truncated) sink beats, then drives the packet.
  task automatic send_packet(input int n, input logic [63:0] base);
    int sel;
    int kept;
    logic last;
    sel  = pick_core(core_idle, m_rr);
    kept = (n > MAX_TDATA_PER_PACKET) ? MAX_TDATA_PER_PACKET : n;
    exp_alloc_q.push_back({2'(sel), 6'(m_tag)});
    for (int i = 1; i <= kept; i++) begin
      last = (i == kept);
      exp_buf_q.push_back({6'(m_tag), last, base + 64'(i)});
      exp_core_q.push_back({2'(sel), 6'(m_tag), last, base + 64'(i)});
    end
    m_tag = (m_tag + 1) % CIRCULAR_BUFFER_SIZE;
    m_rr  = (sel + 1) % N_CORES;
    for (int i = 1; i <= n; i++) drive_beat(base + 64'(i), (i == n), i);
    @(negedge clk);
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int nb0;
  initial begin
    rst_n = 1'b0;
    in_TDATA = 64'hDEAD_BEEF_0123_4567;
    in_TLAST = 1'b1;
    in_TVALID = 1'b1;
    buffer_TREADY = 1'b1;
    core_TREADY = 4'hF;
    core_idle = 4'hF;
    tag_release = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_in_TREADY",       80'(in_TREADY), 80'd0);
    check("rst_buffer_TVALID",   80'(buffer_TVALID), 80'd0);
    check("rst_buffer_TDATA",    80'(buffer_TDATA), 80'd0);
    check("rst_core_TVALID",     80'(core_TVALID), 80'd0);
    check("rst_tag_alloc_valid", 80'(tag_alloc_valid), 80'd0);
    check("rst_reorder_tag",     80'(reorder_tag_in), 80'd0);
    check("rst_state",           80'(o_dbg_state), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_TVALID = 1'b0;
    in_TLAST = 1'b0;

    // Three 4-beat packets, everything idle and ready.
    for (int p = 0; p < 3; p++) send_packet(4, 64'(p + 1) << 16);
    check("t1_tag0",  80'(obs_tag[0]), 80'd0);
    check("t1_tag1",  80'(obs_tag[1]), 80'd1);
    check("t1_tag2",  80'(obs_tag[2]), 80'd2);
    check("t1_core0", 80'(obs_core[0]), 80'd0);
    check("t1_core1", 80'(obs_core[1]), 80'd1);
    check("t1_core2", 80'(obs_core[2]), 80'd2);
    check("t1_buf_beats", 80'(n_buf_beats), 80'd12);
    check("t1_buf_lasts", 80'(n_buf_lasts), 80'd3);

    // Selected core (3) deasserts ready for two cycles mid-packet.
    fork
      send_packet(6, 64'h4 << 16);
      begin
        repeat (4) @(negedge clk);
        core_TREADY = 4'b0111;
        repeat (2) begin
          #4;
          check("stall_buffer_TVALID", 80'(buffer_TVALID), 80'd0);
          check("stall_in_TREADY",     80'(in_TREADY), 80'd0);
          @(negedge clk);
        end
        core_TREADY = 4'hF;
      end
    join
    check("t2_core", 80'(obs_core[3]), 80'd3);

    // Arbitration with sparse idle vectors, rr_ptr back at 0.
    core_idle = 4'b0100;
    send_packet(2, 64'h5 << 16);
    check("t3_core_only2", 80'(obs_core[4]), 80'd2);
    core_idle = 4'b1001;
    send_packet(2, 64'h6 << 16);
    check("t3_core_skip", 80'(obs_core[5]), 80'd3);
    core_idle = 4'hF;

    // 400-beat packet truncated at 375, remainder drained.
    nb0 = n_buf_beats;
    send_packet(400, 64'h7 << 16);
    check("t4_kept_beats", 80'(n_buf_beats - nb0), 80'd375);
    check("t4_drain_ready", 80'(drain_stalls), 80'd0);
    send_packet(1, 64'h8 << 16);
    check("t4_next_tag", 80'(obs_tag[7]), 80'd7);

    // Reset during beat 3 abandons the packet; model restarts from scratch.
    exp_alloc_q.push_back({2'(pick_core(core_idle, m_rr)), 6'(m_tag)});
    for (int i = 1; i <= 3; i++) begin
      exp_buf_q.push_back({6'(m_tag), 1'b0, (64'h9 << 16) + 64'(i)});
      exp_core_q.push_back({2'(pick_core(core_idle, m_rr)), 6'(m_tag), 1'b0, (64'h9 << 16) + 64'(i)});
    end
    drive_beat((64'h9 << 16) + 64'd1, 1'b0, 1);
    drive_beat((64'h9 << 16) + 64'd2, 1'b0, 2);
    @(negedge clk);
    in_TDATA = (64'h9 << 16) + 64'd3;
    rst_n = 1'b0;
    @(negedge clk);
    #4;
    check("mrst_in_TREADY",     80'(in_TREADY), 80'd0);
    check("mrst_buffer_TVALID", 80'(buffer_TVALID), 80'd0);
    check("mrst_core_TVALID",   80'(core_TVALID), 80'd0);
    check("mrst_buffer_TLAST",  80'(buffer_TLAST), 80'd0);
    check("mrst_alloc_valid",   80'(tag_alloc_valid), 80'd0);
    check("mrst_state",         80'(o_dbg_state), 80'd0);
    check("mrst_tag",           80'(reorder_tag_in), 80'd0);
    check("mrst_queues_empty",  80'(exp_buf_q.size() + exp_core_q.size() + exp_alloc_q.size()), 80'd0);
    rst_n = 1'b1;
    in_TVALID = 1'b0;
    m_tag = 0;
    m_rr  = 0;
    send_packet(2, 64'hA << 16);
    check("mrst_next_tag", 80'(obs_tag[obs_tag.size() - 1]), 80'd0);

    // Fill every slot (1 + 49 packets); the next one must wait for a release.
    for (int p = 0; p < 49; p++) send_packet(1, 64'(p + 16) << 16);
    check("fill_last_tag", 80'(obs_tag[obs_tag.size() - 1]), 80'd49);
    fork
      send_packet(1, 64'hFF << 16);
      begin
        repeat (4) begin
          @(negedge clk);
          #4;
          check("full_in_TREADY", 80'(in_TREADY), 80'd0);
          check("full_alloc",     80'(tag_alloc_valid), 80'd0);
        end
        @(negedge clk);
        tag_release = 1'b1;
        @(negedge clk);
        tag_release = 1'b0;
      end
    join
    check("wrap_tag", 80'(obs_tag[obs_tag.size() - 1]), 80'd0);

    repeat (3) @(negedge clk);
    check("end_buf_q",   80'(exp_buf_q.size()), 80'd0);
    check("end_core_q",  80'(exp_core_q.size()), 80'd0);
    check("end_alloc_q", 80'(exp_alloc_q.size()), 80'd0);
    finish_run();
  end

  initial begin
    #300000;
    check("global_timeout", 80'd0, 80'd1);
    finish_run();
  end
endmodule
